load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255, max cycles mem_req_o may wait for mem_ack_i (1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: start_i  in  1  request strobe; operands sampled on the accepting edge.
REQ-005 Port: is_store_i  in  1  1 = store (SB/SH/SW), 0 = load.
REQ-006 Port: funct3_i  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 Port: base_i  in  32  register-bank RS1 data.
REQ-008 Port: offset_i  in  32  sign-extended immediate.
REQ-009 Port: store_data_i  in  32  register-bank RS2 data.
REQ-010 Port: rd_addr_i  in  5  load destination register.
REQ-011 Port: mem_req_o / mem_we_o  out  1 each  bus request / write select.
REQ-012 Port: mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 Port: mem_wdata_o  out  32, mem_wstrb_o  out  4  store data and byte-lane enables.
REQ-014 Port: mem_rdata_i  in  32, mem_ack_i  in  1  read data and bus completion.
REQ-015 Port: busy_o, done_o, err_o  out  1 each  busy flag, completion pulse, error flag (valid with done_o).
REQ-016 Port: wr_en_o  out  1, RD_ADDR_o  out  5, data_o  out  32  register-bank write port.

Function
REQ-017 The block SHALL implement states IDLE, REQ, DONE.
REQ-018 In IDLE, start_i=1 SHALL latch operands, compute addr = base_i + offset_i mod 2^32 and move to REQ (legal) or DONE with err (illegal).
REQ-019 Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}; H/HU with addr[0]=1; W with addr[1:0]!=0.
REQ-020 An illegal request SHALL issue no mem_req_o and SHALL never assert wr_en_o.
REQ-021 In REQ, mem_req_o SHALL be 1, with mem_addr_o/mem_we_o/mem_wdata_o/mem_wstrb_o stable until the ack edge.
REQ-022 mem_ack_i=1 sampled in REQ SHALL capture mem_rdata_i and move to DONE; acks outside REQ SHALL be ignored.
REQ-023 An ack-wait counter SHALL clear on entering REQ and increment per REQ cycle without ack.
REQ-024 If the counter reaches ACK_TIMEOUT, the block SHALL drop mem_req_o and move to DONE with err_o=1.
REQ-025 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-026 Fastest legal latency: start edge k, mem_req_o high cycle k+1, ack same cycle, done_o cycle k+2.
REQ-027 busy_o SHALL be 1 in REQ and DONE; start_i while busy SHALL be ignored.
REQ-028 Stores SHALL drive wstrb: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111.
REQ-029 Store wdata SHALL be: SB byte replicated x4, SH halfword replicated x2, SW as-is.
REQ-030 Loads SHALL take mem_rdata_i >> (8*addr[1:0]); B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-031 wr_en_o SHALL pulse with done_o only for error-free loads with rd_addr!=0; RD_ADDR_o/data_o valid then.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, counter 0, and all outputs 0, including mid-transaction; no done_o for an aborted access.

Verification
REQ-033 LW base 0x100 off 4, rd 5, ack with 0xDEADBEEF -> mem_addr 0x104, we 0, done_o; wr_en_o, RD_ADDR_o 5, data_o 0xDEADBEEF.
REQ-034 LB addr 0x103, rdata 0x80123456 -> data_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH addr 0x102, store_data 0x1234ABCD -> mem_addr 0x100, wstrb 4'b1100, wdata 0xABCDABCD; wr_en_o stays 0.
REQ-036 LW addr 0x101 -> mem_req_o never 1, done_o+err_o at k+1, wr_en_o 0; funct3 011 load -> same.
REQ-037 Legal load, ack withheld -> mem_req_o drops after ACK_TIMEOUT cycles, done_o+err_o 1, wr_en_o 0.
REQ-038 rst in REQ -> mem_req_o/busy_o fall 0 before next edge; new LW after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one bus access at a time with byte-lane steering
// and load extension, with error reporting for misaligned/illegal requests and for ack timeouts.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] base_i,
    input  logic [31:0] offset_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        wr_en_o,
    output logic [4:0]  RD_ADDR_o,
    output logic [31:0] data_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic        r_isStore;
    logic [31:0] r_storeData;
    logic [4:0]  r_rd;
    logic        r_err;
    logic [7:0]  r_cnt;
    logic [31:0] r_data;

    logic [31:0] w_addr;
    logic        w_legal;
    logic        w_accept;
    logic        w_timeout;
    logic [31:0] w_shift;
    logic [31:0] w_loadData;
    logic [31:0] w_storeData;
    logic [3:0]  w_storeStrb;
    logic        w_wrEn;

    assign w_addr    = base_i + offset_i;
    assign w_accept  = (r_state == S_IDLE) && start_i;
    assign w_timeout = (r_cnt == TIMEOUT_LAST);

    // Width-code legality plus natural alignment of the effective address
    always_comb begin
        w_legal = 1'b0;
        if (is_store_i) begin
            w_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        end else begin
            w_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b101);
        end
        if ((funct3_i[1:0] == 2'b01) && w_addr[0]) begin
            w_legal = 1'b0;
        end
        if ((funct3_i == 3'b010) && (w_addr[1:0] != 2'b00)) begin
            w_legal = 1'b0;
        end
    end

    assign w_shift = mem_rdata_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_loadData = w_shift;
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_loadData = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_loadData = {24'h0, w_shift[7:0]};
            3'b101:  w_loadData = {16'h0, w_shift[15:0]};
            default: w_loadData = w_shift;
        endcase
    end

    always_comb begin
        w_storeData = r_storeData;
        w_storeStrb = 4'b1111;
        case (r_funct3)
            3'b000: begin
                w_storeData = {4{r_storeData[7:0]}};
                w_storeStrb = 4'b0001 << r_addr[1:0];
            end
            3'b001: begin
                w_storeData = {2{r_storeData[15:0]}};
                w_storeStrb = 4'b0011 << r_addr[1:0];
            end
            default: begin
                w_storeData = r_storeData;
                w_storeStrb = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = w_legal ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (mem_ack_i || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture at accept; ack-wait counting and read-data capture while in REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= 32'h0;
            r_funct3    <= 3'b000;
            r_isStore   <= 1'b0;
            r_storeData <= 32'h0;
            r_rd        <= 5'd0;
            r_err       <= 1'b0;
            r_cnt       <= 8'd0;
            r_data      <= 32'h0;
        end else if (w_accept) begin
            r_addr      <= w_addr;
            r_funct3    <= funct3_i;
            r_isStore   <= is_store_i;
            r_storeData <= store_data_i;
            r_rd        <= rd_addr_i;
            r_err       <= ~w_legal;
            r_cnt       <= 8'd0;
        end else if (r_state == S_REQ) begin
            if (mem_ack_i) begin
                r_data <= w_loadData;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign w_wrEn = ~r_err && ~r_isStore && (r_rd != 5'd0);

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        mem_wstrb_o = 4'h0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        wr_en_o     = 1'b0;
        RD_ADDR_o   = 5'd0;
        data_o      = 32'h0;
        case (r_state)
            S_REQ: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_we_o   = r_isStore;
                mem_addr_o = {r_addr[31:2], 2'b00};
                if (r_isStore) begin
                    mem_wdata_o = w_storeData;
                    mem_wstrb_o = w_storeStrb;
                end
            end
            S_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                err_o   = r_err;
                wr_en_o = w_wrEn;
                if (w_wrEn) begin
                    RD_ADDR_o = r_rd;
                    data_o    = r_data;
                end
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized transactions
// against an arithmetic reference model, and reset/timeout/stray-ack sequences.
module tb_load_store_unit;

    localparam int T = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] base_i;
    logic [31:0] offset_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_addr_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        wr_en_o;
    logic [4:0]  RD_ADDR_o;
    logic [31:0] data_o;

    load_store_unit #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .is_store_i(is_store_i),
        .funct3_i(funct3_i), .base_i(base_i), .offset_i(offset_i),
        .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wr_en_o(wr_en_o), .RD_ADDR_o(RD_ADDR_o), .data_o(data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        isStore;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ackDelay;
        logic        expIllegal;
        logic [31:0] expAddr;
        logic [3:0]  expWstrb;
        logic [31:0] expWdata;
        logic        expWrEn;
        logic [31:0] expData;
    } vec_t;

    int total = 0;
    int bad   = 0;

    int          obsReq;
    int          obsDone;
    logic [31:0] obsAddr;
    logic        obsWe;
    logic [3:0]  obsWstrb;
    logic [31:0] obsWdata;
    logic        obsStable;
    logic        obsErr;
    logic        obsWrEn;
    logic [4:0]  obsRd;
    logic [31:0] obsData;
    logic        obsBusyAfter;
    logic        obsDoneAfter;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: effective address, legality and lane/extension rules in plain arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        logic [31:0] a;
        logic [31:0] val;
        logic [31:0] x;
        int          b;
        logic        legal;
        r = v;
        a = v.base + v.off;
        b = int'(a % 4);
        if (v.isStore) legal = (v.f3 <= 3'd2);
        else legal = (v.f3 <= 3'd2) || (v.f3 == 3'd4) || (v.f3 == 3'd5);
        if ((v.f3 == 3'd1 || v.f3 == 3'd5) && (a % 2 != 0)) legal = 1'b0;
        if (v.f3 == 3'd2 && b != 0) legal = 1'b0;
        r.expIllegal = ~legal;
        r.expAddr    = a - 32'(b);
        r.expWstrb   = 4'h0;
        r.expWdata   = 32'h0;
        r.expData    = 32'h0;
        if (v.isStore) begin
            if (v.f3 == 3'd0) begin
                r.expWstrb = 4'(1 << b);
                r.expWdata = (v.sd & 32'hFF) * 32'h01010101;
            end else if (v.f3 == 3'd1) begin
                r.expWstrb = 4'(3 << b);
                r.expWdata = (v.sd & 32'hFFFF) * 32'h00010001;
            end else begin
                r.expWstrb = 4'hF;
                r.expWdata = v.sd;
            end
        end else begin
            val = v.rdata >> (8 * b);
            case (v.f3)
                3'd0: begin x = val & 32'hFF;   if (x >= 32'd128)   x = x - 32'd256;   end
                3'd1: begin x = val & 32'hFFFF; if (x >= 32'd32768) x = x - 32'd65536; end
                3'd4: x = val & 32'hFF;
                3'd5: x = val & 32'hFFFF;
                default: x = val;
            endcase
            r.expData = x;
        end
        r.expWrEn = legal && !v.isStore && (v.rd != 0) && (v.ackDelay >= 0) && (v.ackDelay < T);
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        obsReq = 0; obsDone = -1; obsStable = 1'b1;
        obsAddr = 32'h0; obsWe = 1'b0; obsWstrb = 4'h0; obsWdata = 32'h0;
        obsErr = 1'b0; obsWrEn = 1'b0; obsRd = 5'd0; obsData = 32'h0;
        obsBusyAfter = 1'b1; obsDoneAfter = 1'b1;
        @(negedge clk);
        start_i = 1'b1; is_store_i = v.isStore; funct3_i = v.f3; base_i = v.base;
        offset_i = v.off; store_data_i = v.sd; rd_addr_i = v.rd; mem_rdata_i = v.rdata;
        @(negedge clk);
        for (int c = 1; c <= T + 6; c++) begin
            mem_ack_i = 1'b0;
            // Garbage requests while busy must be ignored and must not disturb latched operands
            start_i = mem_req_o; is_store_i = $urandom_range(0, 1); funct3_i = 3'($urandom);
            base_i = $urandom; offset_i = $urandom; store_data_i = $urandom; rd_addr_i = 5'($urandom);
            if (mem_req_o) begin
                if (obsReq == 0) begin
                    obsAddr = mem_addr_o; obsWe = mem_we_o; obsWstrb = mem_wstrb_o; obsWdata = mem_wdata_o;
                end else if (obsAddr !== mem_addr_o || obsWe !== mem_we_o ||
                             obsWstrb !== mem_wstrb_o || obsWdata !== mem_wdata_o) begin
                    obsStable = 1'b0;
                end
                if (v.ackDelay >= 0 && obsReq == v.ackDelay) mem_ack_i = 1'b1;
                obsReq++;
            end
            if (done_o) begin
                obsDone = c; obsErr = err_o; obsWrEn = wr_en_o; obsRd = RD_ADDR_o; obsData = data_o;
                break;
            end
            @(negedge clk);
        end
        mem_ack_i = 1'b0;
        start_i = 1'b0;
        if (obsDone >= 0) begin
            @(negedge clk);
            obsBusyAfter = busy_o;
            obsDoneAfter = done_o;
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        int   expReq;
        int   expDone;
        logic expErr;
        if (v.expIllegal) begin
            expReq = 0; expDone = 1; expErr = 1'b1;
        end else if (v.ackDelay < 0 || v.ackDelay >= T) begin
            expReq = T; expDone = T + 1; expErr = 1'b1;
        end else begin
            expReq = v.ackDelay + 1; expDone = v.ackDelay + 2; expErr = 1'b0;
        end
        cmp({tag, ".reqCycles"}, 32'(obsReq), 32'(expReq));
        cmp({tag, ".doneCycle"}, 32'(obsDone), 32'(expDone));
        cmp({tag, ".err"}, 32'(obsErr), 32'(expErr));
        cmp({tag, ".wrEn"}, 32'(obsWrEn), 32'(v.expWrEn));
        cmp({tag, ".idleAfter"}, 32'({obsBusyAfter, obsDoneAfter}), 32'h0);
        if (expReq > 0) begin
            cmp({tag, ".addr"}, obsAddr, v.expAddr);
            cmp({tag, ".we"}, 32'(obsWe), 32'(v.isStore));
            cmp({tag, ".stable"}, 32'(obsStable), 32'h1);
            if (v.isStore) begin
                cmp({tag, ".wstrb"}, 32'(obsWstrb), 32'(v.expWstrb));
                cmp({tag, ".wdata"}, obsWdata, v.expWdata);
            end
        end
        if (v.expWrEn) begin
            cmp({tag, ".rd"}, 32'(obsRd), 32'(v.rd));
            cmp({tag, ".data"}, obsData, v.expData);
        end
    endtask

    vec_t tbl[14];
    vec_t rv;

    initial begin
        tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5, 32'hDEADBEEF, 0, 1'b0, 32'h104, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'b000, 32'h100, 32'h3, 32'h0, 5'd7, 32'h80123456, 0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 32'hFFFFFF80};
        tbl[2]  = '{1'b0, 3'b100, 32'h100, 32'h3, 32'h0, 5'd7, 32'h80123456, 1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 32'h00000080};
        tbl[3]  = '{1'b1, 3'b001, 32'h100, 32'h2, 32'h1234ABCD, 5'd9, 32'h0, 2, 1'b0, 32'h100, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 3'b010, 32'h100, 32'h1, 32'h0, 5'd5, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 5'd5, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 3'b000, 32'h1000, 32'hFFFFFFFF, 32'h000000A5, 5'd1, 32'h0, 1, 1'b0, 32'hFFC, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 3'b001, 32'h20, 32'h2, 32'h0, 5'd3, 32'h80011234, 3, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 32'hFFFF8001};
        tbl[8]  = '{1'b0, 3'b101, 32'h0, 32'h1, 32'h0, 5'd4, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd0, 32'h12345678, 1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 3'b100, 32'h80, 32'h0, 32'h55, 5'd2, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 5'd6, 32'h0, 0, 1'b0, 32'h4, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 3'b101, 32'h10, 32'h0, 32'h0, 5'd31, 32'h1234F00D, 0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 32'h0000F00D};
        tbl[13] = '{1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd8, 32'h11111111, -1, 1'b0, 32'h300, 4'h0, 32'h0, 1'b0, 32'h0};

        rst = 1'b1; start_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b000; base_i = 32'h0;
        offset_i = 32'h0; store_data_i = 32'h0; rd_addr_i = 5'd0; mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset.req", 32'(mem_req_o), 32'h0);
        cmp("reset.busyDone", 32'({busy_o, done_o, err_o, wr_en_o}), 32'h0);
        cmp("reset.addr", mem_addr_o, 32'h0);
        cmp("reset.data", data_o, 32'h0);
        cmp("reset.rd", 32'(RD_ADDR_o), 32'h0);
        rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d", i), tbl[i]);
        end

        $display("[TB] acks outside REQ are ignored");
        @(negedge clk);
        mem_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        cmp("strayAck.busy", 32'(busy_o), 32'h0);
        cmp("strayAck.done", 32'(done_o), 32'h0);
        mem_ack_i = 1'b0;

        $display("[TB] reset during REQ");
        @(negedge clk);
        start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; base_i = 32'h500;
        offset_i = 32'h0; rd_addr_i = 5'd4; mem_rdata_i = 32'h0BADF00D;
        @(negedge clk);
        start_i = 1'b0;
        cmp("rstMid.reqBefore", 32'(mem_req_o), 32'h1);
        #2 rst = 1'b1;
        #1;
        cmp("rstMid.reqAsync", 32'(mem_req_o), 32'h0);
        cmp("rstMid.busyAsync", 32'(busy_o), 32'h0);
        @(negedge clk);
        cmp("rstMid.noDone", 32'(done_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        cmp("rstMid.idle", 32'({busy_o, done_o}), 32'h0);
        applyStimulus(tbl[0]);
        checkOutput("afterReset", tbl[0]);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 60; i++) begin
            rv.isStore  = 1'($urandom_range(0, 1));
            rv.f3       = 3'($urandom);
            rv.base     = $urandom;
            rv.off      = 32'($urandom_range(0, 15)) - 32'd8;
            rv.sd       = $urandom;
            rv.rd       = 5'($urandom);
            rv.rdata    = $urandom;
            rv.ackDelay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            rv = model(rv);
            applyStimulus(rv);
            checkOutput($sformatf("rand%0d", i), rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
